// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution window datapath.
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int MAX_W  = 416;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } win_state_e;

  // Row-major tap positions around the window centre.
  localparam int TAP_NW = 1;
  localparam int TAP_N  = 2;
  localparam int TAP_NE = 3;
  localparam int TAP_W  = 4;
  localparam int TAP_C  = 5;
  localparam int TAP_E  = 6;
  localparam int TAP_SW = 7;
  localparam int TAP_S  = 8;
  localparam int TAP_SE = 9;

endpackage

// File: rtl/conv_line_buffer.sv
// One-line delay store: simple dual-port RAM, read-first, 1-cycle read latency.
module conv_line_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 416,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Same-address read and write return the old word, which gives the exact one-line delay.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 zero-padded window generator, stride 1.
//
// state | meaning
// IDLE  | waiting for start with a legal W/H
// RUN   | accepting W*H pixels
// FLUSH | injecting W+1 zero beats to drain the last row
// DONE  | waiting for the final window, then pulses done
module conv_window_gen_3x3 #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int MAX_W  = conv_pkg::MAX_W,
  parameter int CNT_W  = conv_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         cfg_width,
  input  logic [CNT_W-1:0]         cfg_height,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DATA_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     done
);
  import conv_pkg::*;

  // [0]=row above, [1]=centre row, [2]=row below
  typedef logic [2:0][DATA_W-1:0] col_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  win_state_e state_q, state_d;
  logic [CNT_W-1:0] w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d, flush_q, flush_d;
  logic [CNT_W-1:0] cen_r_q, cen_r_d, cen_c_q, cen_c_d;
  logic beat_s1_q, beat_s1_d, emit_s1_q, emit_s1_d, last_s1_q, last_s1_d;
  logic [DATA_W-1:0] pix_s1_q, pix_s1_d;
  logic [CNT_W-1:0] addr_s1_q, addr_s1_d, cr_s1_q, cr_s1_d, cc_s1_q, cc_s1_d;
  col_t col1_q, col1_d, col2_q, col2_d, new_col;
  logic [9:1][DATA_W-1:0] tap_q, tap_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic beat, emit, last, cfg_ok, col_end;
  logic top_ok, bot_ok, left_ok, right_ok;
  logic [DATA_W-1:0] pix, lb_mid_rd, lb_top_rd;

  // All state and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      flush_q   <= '0;
      cen_r_q   <= '0;
      cen_c_q   <= '0;
      beat_s1_q <= 1'b0;
      emit_s1_q <= 1'b0;
      last_s1_q <= 1'b0;
      pix_s1_q  <= '0;
      addr_s1_q <= '0;
      cr_s1_q   <= '0;
      cc_s1_q   <= '0;
      col1_q    <= '0;
      col2_q    <= '0;
      tap_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      flush_q   <= flush_d;
      cen_r_q   <= cen_r_d;
      cen_c_q   <= cen_c_d;
      beat_s1_q <= beat_s1_d;
      emit_s1_q <= emit_s1_d;
      last_s1_q <= last_s1_d;
      pix_s1_q  <= pix_s1_d;
      addr_s1_q <= addr_s1_d;
      cr_s1_q   <= cr_s1_d;
      cc_s1_q   <= cc_s1_d;
      col1_q    <= col1_d;
      col2_q    <= col2_d;
      tap_q     <= tap_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  // Sequencer: stream index counters, flush countdown and centre tracking.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    flush_d = flush_q;
    cen_r_d = cen_r_q;
    cen_c_d = cen_c_q;
    beat    = 1'b0;
    emit    = 1'b0;
    last    = 1'b0;
    pix     = '0;
    cfg_ok  = (cfg_width >= CNT_W'(3)) && (cfg_width <= CNT_W'(MAX_W)) &&
              (cfg_height >= CNT_W'(2));
    col_end = (col_q == w_q - ONE);
    unique case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          w_d     = cfg_width;
          h_d     = cfg_height;
          col_d   = '0;
          row_d   = '0;
          cen_r_d = '0;
          cen_c_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          beat = 1'b1;
          pix  = din;
          // The first W+1 beats only prime the line buffers.
          emit = (row_q != '0) && !(row_q == ONE && col_q == '0);
          if (col_end) begin
            col_d = '0;
            row_d = row_q + ONE;
            if (row_q == h_q - ONE) begin
              state_d = FLUSH;
              flush_d = w_q;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      FLUSH: begin
        beat    = 1'b1;
        emit    = 1'b1;
        col_d   = col_end ? '0 : col_q + ONE;
        flush_d = flush_q - ONE;
        if (flush_q == '0) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      if (cen_c_q == w_q - ONE) begin
        cen_c_d = '0;
        cen_r_d = cen_r_q + ONE;
      end else begin
        cen_c_d = cen_c_q + ONE;
      end
    end
  end

  // Window assembly: shift columns on every beat, mask and register taps on emitting beats.
  always_comb begin
    beat_s1_d = beat;
    emit_s1_d = emit;
    last_s1_d = last;
    pix_s1_d  = pix;
    addr_s1_d = col_q;
    cr_s1_d   = cen_r_q;
    cc_s1_d   = cen_c_q;
    col1_d    = col1_q;
    col2_d    = col2_q;
    tap_d     = tap_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    done_d    = last_q;
    new_col   = {pix_s1_q, lb_mid_rd, lb_top_rd};
    top_ok    = (cr_s1_q != '0);
    bot_ok    = (cr_s1_q != h_q - ONE);
    left_ok   = (cc_s1_q != '0);
    right_ok  = (cc_s1_q != w_q - ONE);
    if (beat_s1_q) begin
      col1_d = new_col;
      col2_d = col1_q;
    end
    if (emit_s1_q) begin
      valid_d       = 1'b1;
      last_d        = last_s1_q;
      tap_d[TAP_NW] = (top_ok && left_ok)  ? col2_q[0]  : '0;
      tap_d[TAP_N]  = top_ok               ? col1_q[0]  : '0;
      tap_d[TAP_NE] = (top_ok && right_ok) ? new_col[0] : '0;
      tap_d[TAP_W]  = left_ok              ? col2_q[1]  : '0;
      tap_d[TAP_C]  = col1_q[1];
      tap_d[TAP_E]  = right_ok             ? new_col[1] : '0;
      tap_d[TAP_SW] = (bot_ok && left_ok)  ? col2_q[2]  : '0;
      tap_d[TAP_S]  = bot_ok               ? col1_q[2]  : '0;
      tap_d[TAP_SE] = (bot_ok && right_ok) ? new_col[2] : '0;
    end
  end

  // Centre-row buffer: delays the incoming stream by one line.
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_W), .ADDR_W(CNT_W)) u_lb_mid (
    .clk     (clk),
    .wr_en   (beat),
    .wr_addr (col_q),
    .wr_data (pix),
    .rd_en   (beat),
    .rd_addr (col_q),
    .rd_data (lb_mid_rd)
  );

  // Upper-row buffer: delays the centre row by a further line.
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_W), .ADDR_W(CNT_W)) u_lb_top (
    .clk     (clk),
    .wr_en   (beat_s1_q),
    .wr_addr (addr_s1_q),
    .wr_data (lb_mid_rd),
    .rd_en   (beat),
    .rd_addr (col_q),
    .rd_data (lb_top_rd)
  );

  assign din_ready  = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign dout_valid = valid_q;
  assign w1 = tap_q[TAP_NW];
  assign w2 = tap_q[TAP_N];
  assign w3 = tap_q[TAP_NE];
  assign w4 = tap_q[TAP_W];
  assign w5 = tap_q[TAP_C];
  assign w6 = tap_q[TAP_E];
  assign w7 = tap_q[TAP_SW];
  assign w8 = tap_q[TAP_S];
  assign w9 = tap_q[TAP_SE];

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Scoreboard bench for conv_window_gen_3x3: a frame-level padding model queues expected windows,
// a negedge monitor pops and compares them along with latency and done timing.
module tb_conv_window_gen_3x3;

  localparam int DW = 16;
  localparam int CW = 9;

  typedef logic [8:0][DW-1:0] win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic din_valid = 1'b0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_height = '0;
  logic signed [DW-1:0] din = '0;
  logic din_ready, dout_valid, busy, done;
  logic signed [DW-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;

  win_t   exp_q[$];
  longint lat_q[$];
  longint done_due = -1;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     frame_done = 1'b0;
  win_t   e_w;
  longint e_t;
  logic signed [DW-1:0] pix[$];

  conv_window_gen_3x3 dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
    .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: pop the next expected window whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_window at %0t: got dout_valid=1 expected no window", $time);
        end else begin
          e_w = exp_q.pop_front();
          chk("window_taps", {w9, w8, w7, w6, w5, w4, w3, w2, w1}, e_w);
          if (lat_q.size() != 0) begin
            e_t = lat_q.pop_front();
            chk("window_latency", longint'($time), e_t);
          end
          if (exp_q.size() == 0) done_due = longint'($time) + 10;
        end
      end
      if (done || (longint'($time) == done_due)) begin
        chk("done_pulse", done, (longint'($time) == done_due));
        if (done && longint'($time) == done_due) frame_done = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout_valid"}, dout_valid, 1'b0);
    chk({tag, "_din_ready"}, din_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_taps"}, {w9, w8, w7, w6, w5, w4, w3, w2, w1}, '0);
  endtask

  task automatic start_frame(input int wv, input int hv);
    cfg_width  = CW'(wv);
    cfg_height = CW'(hv);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Present one pixel; on acceptance, record when its window (if any) must appear.
  task automatic drive_beat(input logic signed [DW-1:0] v, input int n, input int wv,
                            input int gap, input bit poke_start);
    int guard = 0;
    din       = v;
    din_valid = 1'b1;
    if (poke_start) begin
      start      = 1'b1;
      cfg_width  = CW'(5);
      cfg_height = CW'(5);
    end
    do begin
      @(negedge clk);
      guard++;
    end while (!din_ready && guard < 50);
    if (!din_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL din_ready_timeout beat %0d: got din_ready=0 expected 1", n);
    end else if (n >= wv + 1) begin
      lat_q.push_back(longint'($time) + 20);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    start     = 1'b0;
    din       = DW'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // data_mode: 0 ramp 1..N, 1 random, 2 all -32768. gap_mode: 0 none, 1 alternate, 2 random.
  task automatic run_frame(input int wv, input int hv, input int data_mode, input int gap_mode,
                           input int poke_at, input int abort_after);
    int gap;
    int guard;
    win_t ew;
    pix.delete();
    for (int i = 0; i < wv * hv; i++) begin
      case (data_mode)
        0:       pix.push_back(DW'(i + 1));
        1:       pix.push_back(DW'($urandom));
        default: pix.push_back(-16'sd32768);
      endcase
    end
    for (int r = 0; r < hv; r++) begin
      for (int c = 0; c < wv; c++) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr >= 0 && r + dr < hv && c + dc >= 0 && c + dc < wv)
              ew[(dr + 1) * 3 + (dc + 1)] = pix[(r + dr) * wv + (c + dc)];
            else
              ew[(dr + 1) * 3 + (dc + 1)] = '0;
          end
        end
        exp_q.push_back(ew);
      end
    end
    frame_done = 1'b0;
    start_frame(wv, hv);
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < wv * hv; i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      drive_beat(pix[i], i, wv, gap, (i == poke_at));
    end
    guard = 0;
    while (!frame_done && guard < 4 * wv * hv + 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (!frame_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout %0dx%0d: got %0d windows outstanding expected 0",
               wv, hv, exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_release");

    run_frame(4, 3, 0, 0, -1, -1);
    run_frame(4, 3, 0, 1, -1, -1);
    run_frame(3, 2, 2, 0, -1, -1);

    start_frame(2, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("illegal_w2_busy", busy, 1'b0);
    chk("illegal_w2_ready", din_ready, 1'b0);
    start_frame(5, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_h1_busy", busy, 1'b0);
    start_frame(417, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_w417_busy", busy, 1'b0);

    run_frame(4, 3, 0, 0, 3, -1);

    run_frame(4, 3, 0, 0, -1, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_frame_reset");
    exp_q.delete();
    lat_q.delete();
    done_due = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(4, 3, 0, 0, -1, -1);

    run_frame(5, 4, 1, 2, -1, -1);
    run_frame(7, 3, 1, 2, 10, -1);
    run_frame(416, 2, 0, 0, -1, -1);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_gen_3x3.md
# conv_window_gen_3x3

Streaming 3x3 sliding-window generator for the stride-1, pad-1 convolution datapath. It accepts one int16 feature-map pixel per beat in raster order and buffers two lines internally. For every pixel position it emits the nine zero-padded neighbourhood values in parallel, in the exact form the 9-input int16 adder-tree stage consumes. It sits between the feature-map fetch stream and the multiplier/adder-tree array.

## Interface
- DATA_W, 16: pixel width, signed two's complement.
- MAX_W, 416: maximum line width; sets line-buffer depth.
- CNT_W, 9: width of the row/column counters and config ports; must satisfy 2^CNT_W > MAX_W.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_width/cfg_height and begins a frame.
- cfg_width  in  CNT_W  frame width W, legal range 3..MAX_W.
- cfg_height  in  CNT_W  frame height H, legal range 2..511.
- din  in  DATA_W  pixel, signed.
- din_valid  in  1  din holds a pixel.
- din_ready  out  1  block accepts a pixel this cycle.
- w1..w9  out  DATA_W each  window taps, row-major; w1=(r-1,c-1), w5=(r,c), w9=(r+1,c+1).
- dout_valid  out  1  w1..w9 hold the window centred at (r,c).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last window.

## Operation
- States:
  - IDLE: start with legal config latches W and H, clears counters, goes to RUN. start with illegal config is ignored.
  - RUN: din_ready=1. Each accepted beat (din_valid & din_ready) advances the stream index n. After beat W*H-1 is accepted, go to FLUSH.
  - FLUSH: din_ready=0. The block injects W+1 internal zero beats, one per cycle, unconditionally. Then go to DONE.
  - DONE: pulses done when the final window's dout_valid has been issued, then returns to IDLE.
- start is ignored outside IDLE.
- Stream index n covers input beats 0..W*H-1 and flush beats W*H..W*H+W. Beat n produces the window centred at index n-W-1, for n ≥ W+1. This yields exactly W*H windows per frame, in raster order of centre.
- Padding mask (taps forced to 0, centre (r,c)):
  - r=0 zeroes w1..w3.
  - r=H-1 zeroes w7..w9.
  - c=0 zeroes w1, w4, w7.
  - c=W-1 zeroes w3, w6, w9.
- Taps are pure copies of pixels; no arithmetic, no width change.
- Line buffers hold rows r and r+1. Buffer addresses wrap at W, not MAX_W. Stale contents from a prior frame are never visible, because of the mask.
- busy=1 in RUN, FLUSH and DONE.

## Timing
- Reset values: dout_valid=0, din_ready=0, busy=0, done=0, w1..w9=0, state=IDLE. Line-buffer RAM is not cleared.
- Latency: dout_valid rises exactly 2 cycles after the cycle in which beat n (accepted or flush) is taken. Taps are registered.
- Input stalls (din_valid=0 in RUN) stall the pipeline. No output bubble is emitted for a stall beyond the matching gap.
- Flush runs back-to-back: W+1 consecutive cycles.
- done is asserted in the cycle after the final dout_valid.
- Earliest start accepted for the next frame: the cycle after done.
- rst_n low mid-frame: all outputs go to reset values immediately (asynchronous). No partial window is emitted after release. The block waits in IDLE for a new start.

## Structure
- Shared package conv_pkg:
  - DATA_W and MAX_W constants.
  - window-generator state enum: IDLE, RUN, FLUSH, DONE.
  - tap index constants TAP_NW..TAP_SE (1..9).
- One sub-module, conv_line_buffer: simple dual-port RAM, MAX_W x DATA_W. One write port and one read port with 1-cycle synchronous read. Two instances.

## Test plan
- W=4, H=3, pixels 1..12, din_valid held high. Expect 12 windows.
  - Centre (0,0): w5=1, w6=2, w8=5, w9=6, others 0.
  - Centre (1,1): w1..w9 = 1, 2, 3, 5, 6, 7, 9, 10, 11.
  - Centre (2,3): w1=7, w2=8, w4=11, w5=12, others 0.
  - done one cycle after the 12th dout_valid.
- Same frame with din_valid toggling 1,0,1,0. Expect identical window sequence, each dout_valid 2 cycles after the triggering accepted beat, and no windows during gaps.
- Negative data: W=3, H=2, all pixels -32768. Centre (0,1): w4..w9 = -32768, w1..w3 = 0. No sign corruption.
- start with cfg_width=2 → ignored: busy stays 0, din_ready stays 0. start during RUN → ignored, frame completes normally.
- rst_n pulsed low after 5 beats of a 4x3 frame. Outputs go to 0 immediately. A new 4x3 frame after start matches the first scenario exactly.
- W=MAX_W=416, H=2, ramp data. Expect 832 windows. Address wrap is correct at column 415, and centre (1,415) has w3, w6, w9 and w7..w9 zero.
